// File: rtl/alu_logic_mc_pkg.sv
// Shared EX-stage definitions for the logic/shift/HI-LO unit.
package alu_logic_mc_pkg;

  localparam int unsigned EX_OP_LOW_BUS = 4;

  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_AND        = 4'd0;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_OR         = 4'd1;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_XOR        = 4'd2;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_NOR        = 4'd3;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_LUI        = 4'd4;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_SHLEFT     = 4'd5;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_SHRIGHTLOG = 4'd6;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_SHRIGHTARI = 4'd7;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_FROMHI     = 4'd8;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_FROMLO     = 4'd9;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_TOHI       = 4'd10;
  localparam logic [EX_OP_LOW_BUS-1:0] EX_LOGIC_TOLO       = 4'd11;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0;

  function automatic logic is_shift_op(input logic [EX_OP_LOW_BUS-1:0] op);
    return op inside {EX_LOGIC_SHLEFT, EX_LOGIC_SHRIGHTLOG, EX_LOGIC_SHRIGHTARI};
  endfunction

endpackage

// File: rtl/alu_logic_mc_shift_step.sv
// One iteration of the multi-cycle shifter: shift by 0..STEP bits with a fill bit.
module alu_shift_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             left_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  // Left shifts zero-fill; right shifts OR in the fill bit over the vacated MSBs.
  always_comb begin
    if (left_i) begin
      data_o = data_i << amt_i;
    end else begin
      data_o = (data_i >> amt_i) | (fill_i ? ~({WIDTH{1'b1}} >> amt_i) : '0);
    end
  end

endmodule

// File: rtl/alu_logic_mc.sv
// Multi-cycle logic / iterative shift / HI-LO move unit for the EX stage.
module alu_logic_mc
  import alu_logic_mc_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 4,
  parameter int unsigned OP_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] src_left,
  input  logic [WIDTH-1:0] src_right,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             o_we,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             busy
);

  localparam int unsigned AMT_W = $clog2(STEP + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     o_hi_q, o_hi_d;
  logic [WIDTH-1:0]     o_lo_q, o_lo_d;
  logic                 o_we_q, o_we_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic                 left_q, left_d;
  logic                 fill_q, fill_d;

  logic [EX_OP_LOW_BUS-1:0] op_l;
  logic [SHAMT_W-1:0]       shamt;
  logic [SHAMT_W-1:0]       rem_next;
  logic [AMT_W-1:0]         step_amt;
  logic [WIDTH-1:0]         shift_out;
  logic                     accept;
  logic [WIDTH-1:0]         one_res, one_hi, one_lo;
  logic                     one_we;

  assign op_l     = EX_OP_LOW_BUS'(op);
  assign shamt    = src_left[SHAMT_W-1:0];
  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  // Bits to shift this cycle: min(STEP, remaining).
  always_comb begin
    if (32'(rem_q) >= STEP) begin
      step_amt = AMT_W'(STEP);
    end else begin
      step_amt = AMT_W'(rem_q);
    end
  end

  assign rem_next = rem_q - SHAMT_W'(step_amt);

  alu_shift_step #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_shift_step (
    .data_i (result_q),
    .amt_i  (step_amt),
    .left_i (left_q),
    .fill_i (fill_q),
    .data_o (shift_out)
  );

  // Single-cycle results; shifts by zero simply pass the shiftee through.
  always_comb begin
    one_res = '0;
    one_we  = DISABLE;
    one_hi  = '0;
    one_lo  = '0;
    case (op_l)
      EX_LOGIC_AND:        one_res = src_left & src_right;
      EX_LOGIC_OR:         one_res = src_left | src_right;
      EX_LOGIC_XOR:        one_res = src_left ^ src_right;
      EX_LOGIC_NOR:        one_res = ~(src_left | src_right);
      EX_LOGIC_LUI:        one_res = {src_right[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      EX_LOGIC_SHLEFT,
      EX_LOGIC_SHRIGHTLOG,
      EX_LOGIC_SHRIGHTARI: one_res = src_right;
      EX_LOGIC_FROMHI:     one_res = hi;
      EX_LOGIC_FROMLO:     one_res = lo;
      EX_LOGIC_TOHI: begin
        one_we = ENABLE;
        one_hi = src_left;
        one_lo = lo;
      end
      EX_LOGIC_TOLO: begin
        one_we = ENABLE;
        one_hi = hi;
        one_lo = src_left;
      end
      default: ;
    endcase
  end

  // Next-state: shift iteration, result hand-off, accept, then flush overriding all.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    o_we_d   = o_we_q;
    o_hi_d   = o_hi_q;
    o_lo_d   = o_lo_q;
    rem_d    = rem_q;
    left_d   = left_q;
    fill_d   = fill_q;

    case (state_q)
      StShift: begin
        result_d = shift_out;
        rem_d    = rem_next;
        if (rem_next == '0) state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          o_we_d  = DISABLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (is_shift_op(op_l) && (shamt != '0)) begin
        state_d  = StShift;
        rem_d    = shamt;
        result_d = src_right;
        left_d   = (op_l == EX_LOGIC_SHLEFT);
        // Sign is captured once here; later iterations replicate it.
        fill_d   = (op_l == EX_LOGIC_SHRIGHTARI) & src_right[WIDTH-1];
        o_we_d   = DISABLE;
        o_hi_d   = '0;
        o_lo_d   = '0;
      end else begin
        state_d  = StDone;
        result_d = one_res;
        o_we_d   = one_we;
        o_hi_d   = one_hi;
        o_lo_d   = one_lo;
      end
    end

    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
      o_we_d   = DISABLE;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      o_we_q   <= 1'b0;
      o_hi_q   <= '0;
      o_lo_q   <= '0;
      rem_q    <= '0;
      left_q   <= 1'b0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      o_we_q   <= o_we_d;
      o_hi_q   <= o_hi_d;
      o_lo_q   <= o_lo_d;
      rem_q    <= rem_d;
      left_q   <= left_d;
      fill_q   <= fill_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign o_we      = o_we_q;
  assign o_hi      = o_hi_q;
  assign o_lo      = o_lo_q;

endmodule

// File: tb/tb_alu_logic_mc.sv
// Scoreboard bench for alu_logic_mc (WIDTH=32, STEP=4).
module tb_alu_logic_mc;
  import alu_logic_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, o_we, busy;
  logic [3:0]  op;
  logic [31:0] src_left, src_right, hi, lo, result, o_hi, o_lo;

  typedef struct {
    logic [31:0] result;
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] h;
    logic [31:0] lw;
  } stim_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  alu_logic_mc #(
    .WIDTH   (32),
    .SHAMT_W (5),
    .STEP    (4),
    .OP_W    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_left  (src_left),
    .src_right (src_right),
    .hi        (hi),
    .lo        (lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .o_we      (o_we),
    .o_hi      (o_hi),
    .o_lo      (o_lo),
    .busy      (busy)
  );

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] l, r, h, lw);
    exp_t e;
    int   k;
    k = int'(l[4:0]);
    e.result = 32'h0;
    e.we     = 1'b0;
    e.hi     = 32'h0;
    e.lo     = 32'h0;
    e.lat    = 1;
    case (o)
      EX_LOGIC_AND:        e.result = l & r;
      EX_LOGIC_OR:         e.result = l | r;
      EX_LOGIC_XOR:        e.result = l ^ r;
      EX_LOGIC_NOR:        e.result = ~(l | r);
      EX_LOGIC_LUI:        e.result = {r[15:0], 16'h0};
      EX_LOGIC_SHLEFT:     e.result = r << k;
      EX_LOGIC_SHRIGHTLOG: e.result = r >> k;
      EX_LOGIC_SHRIGHTARI: e.result = 32'($signed(r) >>> k);
      EX_LOGIC_FROMHI:     e.result = h;
      EX_LOGIC_FROMLO:     e.result = lw;
      EX_LOGIC_TOHI: begin e.we = 1'b1; e.hi = l; e.lo = lw; end
      EX_LOGIC_TOLO: begin e.we = 1'b1; e.hi = h; e.lo = l; end
      default: ;
    endcase
    if (o inside {EX_LOGIC_SHLEFT, EX_LOGIC_SHRIGHTLOG, EX_LOGIC_SHRIGHTARI} && k != 0)
      e.lat = 1 + (k + 3) / 4;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after the accept.
  task automatic drive_op(input logic [3:0] o, input logic [31:0] l, r, h, lw);
    int guard = 0;
    op = o; src_left = l; src_right = r; hi = h; lo = lw; in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    tests_run++;
    if (guard >= 50) begin
      tests_failed++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
    end
    sb.push_back(model(o, l, r, h, lw));
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); src_left = $urandom; src_right = $urandom; hi = $urandom; lo = $urandom;
    @(negedge clk);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid, o_we, result, o_hi, o_lo, in_ready, busy} !== {1'b0, 1'b0, 96'h0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: got v=%b we=%b res=%h hi=%h lo=%h rdy=%b busy=%b, required 0 0 0 0 0 1 0",
               out_valid, o_we, result, o_hi, o_lo, in_ready, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_table(input string name, input stim_t t[]);
    exp_t e;
    int   lat;
    foreach (t[i]) begin
      drive_op(t[i].op, t[i].l, t[i].r, t[i].h, t[i].lw);
      wait_valid(lat);
      e = sb.pop_front();
      tests_run++;
      if ({result, o_we, o_hi, o_lo} !== {e.result, e.we, e.hi, e.lo}) begin
        tests_failed++;
        $display("FAIL %s[%0d] op=%0d: got res=%h we=%b hi=%h lo=%h, required res=%h we=%b hi=%h lo=%h",
                 name, i, t[i].op, result, o_we, o_hi, o_lo, e.result, e.we, e.hi, e.lo);
      end
      tests_run++;
      if (lat !== e.lat) begin
        tests_failed++;
        $display("FAIL %s[%0d]_latency: got %0d, required %0d", name, i, lat, e.lat);
      end
      take();
      tests_run++;
      if (out_valid !== 1'b0 || o_we !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s[%0d]_release: got v=%b we=%b, required 0 0", name, i, out_valid, o_we);
      end
    end
  endtask

  task automatic test_logic();
    stim_t t[] = '{
      '{EX_LOGIC_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0},
      '{EX_LOGIC_OR,  32'h12340000, 32'h00005678, 32'h0, 32'h0},
      '{EX_LOGIC_XOR, 32'hFFFF0000, 32'hF0F0F0F0, 32'h0, 32'h0},
      '{EX_LOGIC_NOR, 32'h0000FFFF, 32'h00FF0000, 32'h0, 32'h0},
      '{EX_LOGIC_LUI, 32'h0,        32'hCAFE1234, 32'h0, 32'h0}
    };
    run_table("logic", t);
  endtask

  task automatic test_shift();
    stim_t t[] = '{
      '{EX_LOGIC_SHRIGHTARI, 32'd31, 32'h80000010, 32'h0, 32'h0},
      '{EX_LOGIC_SHRIGHTLOG, 32'd31, 32'h80000010, 32'h0, 32'h0},
      '{EX_LOGIC_SHLEFT,     32'd0,  32'hDEADBEEF, 32'h0, 32'h0},
      '{EX_LOGIC_SHLEFT,     32'd5,  32'h00000001, 32'h0, 32'h0},
      '{EX_LOGIC_SHRIGHTARI, 32'hFFFFFFE4, 32'h9000F000, 32'h0, 32'h0},
      '{EX_LOGIC_SHLEFT,     32'd8,  32'h00ABCDEF, 32'h0, 32'h0}
    };
    run_table("shift", t);
  endtask

  task automatic test_hilo();
    stim_t t[] = '{
      '{EX_LOGIC_TOHI,   32'h12345678, 32'h0, 32'h11112222, 32'hAAAA5555},
      '{EX_LOGIC_TOLO,   32'h87654321, 32'h0, 32'h11112222, 32'hAAAA5555},
      '{EX_LOGIC_FROMHI, 32'h0,        32'h0, 32'h0BADF00D, 32'h5EED5EED},
      '{EX_LOGIC_FROMLO, 32'h0,        32'h0, 32'h0BADF00D, 32'h5EED5EED},
      '{4'd14,           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h2}
    };
    run_table("hilo", t);
  endtask

  task automatic test_random();
    stim_t t[] = new[16];
    foreach (t[i]) begin
      t[i].op = 4'($urandom_range(0, 15));
      t[i].l  = $urandom;
      t[i].r  = $urandom;
      t[i].h  = $urandom;
      t[i].lw = $urandom;
    end
    run_table("random", t);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    drive_op(EX_LOGIC_OR, 32'h000000F0, 32'h0000000F, 32'h0, 32'h0);
    wait_valid(lat);
    e = sb.pop_front();
    tests_run++;
    if (result !== e.result) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h, required %h", result, e.result);
    end
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, e.result}) begin
        tests_failed++;
        $display("FAIL b2b_hold: got v=%b rdy=%b res=%h, required 1 0 %h",
                 out_valid, in_ready, result, e.result);
      end
    end
    op = EX_LOGIC_XOR; src_left = 32'hA5A5A5A5; src_right = 32'h0F0F0F0F;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready: got %b, required 1", in_ready);
    end
    sb.push_back(model(EX_LOGIC_XOR, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0, 32'h0));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; src_left = 32'h0; src_right = 32'h0;
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if ({out_valid, result} !== {1'b1, e.result}) begin
      tests_failed++;
      $display("FAIL b2b_second: got v=%b res=%h, required 1 %h", out_valid, result, e.result);
    end
    take();
  endtask

  task automatic test_flush();
    int bad = 0;
    drive_op(EX_LOGIC_SHLEFT, 32'd31, 32'h1, 32'h0, 32'h0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL flush_shift: got busy=%b v=%b rdy=%b, required 0 0 1", busy, out_valid, in_ready);
    end
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL flush_quiet: out_valid high in %0d cycles, required 0", bad);
    end
    op = EX_LOGIC_AND; src_left = 32'hFFFFFFFF; src_right = 32'hFFFFFFFF;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    tests_run++;
    if ({busy, out_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_no_accept: got busy=%b v=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_done();
    exp_t e;
    int   lat;
    drive_op(EX_LOGIC_TOHI, 32'h12345678, 32'h0, 32'h0, 32'hAAAA5555);
    wait_valid(lat);
    e = sb.pop_front();
    tests_run++;
    if ({out_valid, o_we, o_hi} !== {1'b1, e.we, e.hi}) begin
      tests_failed++;
      $display("FAIL pre_reset: got v=%b we=%b hi=%h, required 1 %b %h", out_valid, o_we, o_hi, e.we, e.hi);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, o_we, result, o_hi, o_lo, in_ready, busy} !== {1'b0, 1'b0, 96'h0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b we=%b res=%h hi=%h lo=%h rdy=%b busy=%b, required 0 0 0 0 0 1 0",
               out_valid, o_we, result, o_hi, o_lo, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; src_left = 32'h0; src_right = 32'h0; hi = 32'h0; lo = 32'h0;
    test_reset();
    test_logic();
    test_shift();
    test_hilo();
    test_back_to_back();
    test_flush();
    test_reset_mid_done();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
